alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_pkg.sv | 26 ++
 rtl/alu_sequencer_nibble_alu.sv | 44 ++++
 rtl/alu_sequencer.sv | 143 ++++++++++++++
 tb/tb_alu_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared keypad and operation-select codes for the ALU sequencer.
// KEY_0..KEY_9 are the digit keys. Codes above KEY_9 are non-digit keys.
// SL_A/SL_B pick the entry register. SL_ADD..SL_XOR pick the operation.
package alu_sequencer_pkg;

    localparam logic [4:0] KEY_0 = 5'd0;
    localparam logic [4:0] KEY_9 = 5'd9;

    localparam logic [2:0] SL_A   = 3'd0;
    localparam logic [2:0] SL_B   = 3'd1;
    localparam logic [2:0] SL_ADD = 3'd2;
    localparam logic [2:0] SL_SUB = 3'd3;
    localparam logic [2:0] SL_AND = 3'd4;
    localparam logic [2:0] SL_OR  = 3'd5;
    localparam logic [2:0] SL_XOR = 3'd6;

    // KEY_0 is zero, so an upper-bound compare alone identifies a digit key.
    function automatic logic is_digit(input logic [4:0] k);
        return (k <= KEY_9);
    endfunction

    function automatic logic is_op(input logic [2:0] s);
        return (s >= SL_ADD) && (s <= SL_XOR);
    endfunction

endpackage

// File: rtl/alu_sequencer_nibble_alu.sv
// nibble_alu: combinational 4-bit slice of the sequencer datapath.
// Ports:
//   op_i   - SL_* operation code
//   a_i    - A nibble
//   b_i    - B nibble
//   cin_i  - carry in
//   y_o    - result nibble
//   cout_o - carry out (always 0 for the bitwise ops)
module nibble_alu
    import alu_sequencer_pkg::*;
(
    input  logic [2:0] op_i,
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] y_o,
    output logic       cout_o
);
    logic [4:0] sum;

    always_comb begin
        sum    = 5'd0;
        y_o    = 4'd0;
        cout_o = 1'b0;
        case (op_i)
            SL_ADD: begin
                sum    = {1'b0, a_i} + {1'b0, b_i} + {4'd0, cin_i};
                y_o    = sum[3:0];
                cout_o = sum[4];
            end
            // Subtraction is A + ~B + c. The caller presets c=1 on the first
            // nibble, so a final carry of 1 means there was no borrow.
            SL_SUB: begin
                sum    = {1'b0, a_i} + {1'b0, ~b_i} + {4'd0, cin_i};
                y_o    = sum[3:0];
                cout_o = sum[4];
            end
            SL_AND:  y_o = a_i & b_i;
            SL_OR:   y_o = a_i | b_i;
            SL_XOR:  y_o = a_i ^ b_i;
            default: y_o = 4'd0;
        endcase
    end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: keypad-fed, nibble-serial ALU.
// Digits are shifted into reg_a or reg_b while idle.
// A start pulse runs one operation, one nibble per cycle, LSB nibble first.
// Ports:
//   clk, rst        - clock; asynchronous active-high reset
//   key, digit_wr   - keypad code and digit write strobe
//   sel, start      - register/operation select and start pulse
//   busy, end_obl   - operation in progress and one-cycle completion pulse
//   reg_a, reg_b    - operand/result A and operand B
//   carry           - carry/no-borrow flag of the last operation
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      key,
    input  logic            digit_wr,
    input  logic [2:0]      sel,
    input  logic            start,
    output logic            busy,
    output logic            end_obl,
    output logic [4*NDIG-1:0] reg_a,
    output logic [4*NDIG-1:0] reg_b,
    output logic            carry
);
    localparam int W  = 4 * NDIG;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          cin_q, cin_d;
    logic [W-1:0]  res_q, res_d;
    logic [W-1:0]  reg_a_q, reg_a_d;
    logic [W-1:0]  reg_b_q, reg_b_d;
    logic          carry_q, carry_d;

    logic [4:0]    key_off;
    logic [3:0]    digit;
    logic [3:0]    a_nib, b_nib, alu_y;
    logic          alu_cout;
    logic [W-1:0]  res_full;

    assign key_off = key - KEY_0;
    assign digit   = key_off[3:0];

    assign a_nib = reg_a_q[{idx_q, 2'b00} +: 4];
    assign b_nib = reg_b_q[{idx_q, 2'b00} +: 4];

    nibble_alu u_nibble_alu (
        .op_i   (op_q),
        .a_i    (a_nib),
        .b_i    (b_nib),
        .cin_i  (cin_q),
        .y_o    (alu_y),
        .cout_o (alu_cout)
    );

    // Shadow result with the current nibble merged in. On the last nibble,
    // this lets reg_a take the full result on the same edge.
    always_comb begin
        res_full = res_q;
        res_full[{idx_q, 2'b00} +: 4] = alu_y;
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        idx_d   = idx_q;
        cin_d   = cin_q;
        res_d   = res_q;
        reg_a_d = reg_a_q;
        reg_b_d = reg_b_q;
        carry_d = carry_q;
        case (state_q)
            ST_IDLE: begin
                // A valid start wins over a coincident digit write.
                if (start && is_op(sel)) begin
                    op_d    = sel;
                    idx_d   = '0;
                    cin_d   = (sel == SL_SUB);
                    state_d = ST_CALC;
                end else if (digit_wr && is_digit(key)) begin
                    if (sel == SL_A) reg_a_d = (reg_a_q << 4) | W'(digit);
                    else if (sel == SL_B) reg_b_d = (reg_b_q << 4) | W'(digit);
                end
            end
            ST_CALC: begin
                res_d = res_full;
                cin_d = alu_cout;
                if (idx_q == LAST) begin
                    reg_a_d = res_full;
                    carry_d = alu_cout;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                reg_b_d = '0;
                idx_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= SL_ADD;
            idx_q   <= '0;
            cin_q   <= 1'b0;
            res_q   <= '0;
            reg_a_q <= '0;
            reg_b_q <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            cin_q   <= cin_d;
            res_q   <= res_d;
            reg_a_q <= reg_a_d;
            reg_b_q <= reg_b_d;
            carry_q <= carry_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign end_obl = (state_q == ST_DONE);
    assign reg_a   = reg_a_q;
    assign reg_b   = reg_b_q;
    assign carry   = carry_q;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    localparam int NDIG = 4;
    localparam int W    = 4 * NDIG;

    logic         clk = 1'b0;
    logic         rst;
    logic [4:0]   key;
    logic         digit_wr;
    logic [2:0]   sel;
    logic         start;
    logic         busy, end_obl, carry;
    logic [W-1:0] reg_a, reg_b;

    int errors = 0;
    int checks = 0;

    alu_sequencer #(.NDIG(NDIG)) dut (
        .clk(clk), .rst(rst), .key(key), .digit_wr(digit_wr), .sel(sel),
        .start(start), .busy(busy), .end_obl(end_obl), .reg_a(reg_a),
        .reg_b(reg_b), .carry(carry)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic enter_digit(input logic [2:0] s, input logic [4:0] k);
        sel = s; key = k; digit_wr = 1'b1;
        tick();
        digit_wr = 1'b0;
    endtask

    task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int i = NDIG - 1; i >= 0; i--) enter_digit(SL_A, {1'b0, a[i*4 +: 4]});
        for (int i = NDIG - 1; i >= 0; i--) enter_digit(SL_B, {1'b0, b[i*4 +: 4]});
    endtask

    // Reference model: plain full-width arithmetic on the operand values.
    task automatic ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] r, output logic c);
        logic [W:0] s;
        c = 1'b0;
        case (op)
            SL_ADD: begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W]; end
            SL_SUB: begin r = a - b; c = (a >= b); end
            SL_AND: r = a & b;
            SL_OR:  r = a | b;
            default: r = a ^ b;
        endcase
    endtask

    // Pulse start, then watch the run. Collects end_obl count and latency,
    // the result at end_obl, and whether A/B stayed frozen during CALC.
    // With disturb set, it also drives digit_wr and start mid-run.
    task automatic do_op(input logic [2:0] s, input logic disturb,
                         output int ends, output int lat, output logic busy0,
                         output logic stable, output logic [W-1:0] ra, output logic c);
        logic [W-1:0] a0, b0;
        a0 = reg_a; b0 = reg_b;
        ra = '0; c = 1'b0;
        sel = s; start = 1'b1;
        tick();
        start = 1'b0;
        busy0 = busy; ends = 0; lat = -1; stable = 1'b1;
        for (int k = 1; k <= NDIG + 4; k++) begin
            if (disturb && k <= 2) begin
                sel = SL_SUB; key = 5'd3; digit_wr = 1'b1; start = 1'b1;
            end else begin
                digit_wr = 1'b0; start = 1'b0;
            end
            tick();
            if (end_obl) begin
                ends++;
                if (lat < 0) begin lat = k; ra = reg_a; c = carry; end
            end else if (busy && (reg_a !== a0 || reg_b !== b0)) begin
                stable = 1'b0;
            end
        end
        digit_wr = 1'b0; start = 1'b0;
    endtask

    task automatic check_op(input string name, input logic [2:0] op,
                            input logic [W-1:0] a, input logic [W-1:0] b, input logic disturb);
        int ends, lat;
        logic busy0, stable, c, ec;
        logic [W-1:0] ra, er;
        ref_op(op, a, b, er, ec);
        do_op(op, disturb, ends, lat, busy0, stable, ra, c);
        checks++; if (ra !== er) begin errors++; $display("FAIL %s result: got %h want %h", name, ra, er); end
        checks++; if (c !== ec) begin errors++; $display("FAIL %s carry: got %b want %b", name, c, ec); end
        checks++; if (ends != 1) begin errors++; $display("FAIL %s end_obl count: got %0d want 1", name, ends); end
        checks++; if (lat != NDIG) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, NDIG); end
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL %s busy after start: got %b want 1", name, busy0); end
        checks++; if (!stable) begin errors++; $display("FAIL %s regs frozen in CALC: got changed want stable", name); end
        checks++; if (reg_b !== '0) begin errors++; $display("FAIL %s reg_b after done: got %h want 0", name, reg_b); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy after done: got %b want 0", name, busy); end
    endtask

    task automatic test_reset;
        rst = 1'b1; key = '0; digit_wr = 1'b0; sel = SL_A; start = 1'b0;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
        checks++; if (end_obl !== 1'b0) begin errors++; $display("FAIL reset end_obl: got %b want 0", end_obl); end
        checks++; if (reg_a !== '0) begin errors++; $display("FAIL reset reg_a: got %h want 0", reg_a); end
        checks++; if (reg_b !== '0) begin errors++; $display("FAIL reset reg_b: got %h want 0", reg_b); end
        checks++; if (carry !== 1'b0) begin errors++; $display("FAIL reset carry: got %b want 0", carry); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_digit_entry;
        enter_digit(SL_A, 5'd1); enter_digit(SL_A, 5'd2);
        enter_digit(SL_A, 5'd3); enter_digit(SL_A, 5'd4);
        checks++; if (reg_a !== 16'h1234) begin errors++; $display("FAIL digit reg_a: got %h want 1234", reg_a); end
        checks++; if (reg_b !== 16'h0000) begin errors++; $display("FAIL digit reg_b: got %h want 0000", reg_b); end
        enter_digit(SL_A, 5'd12);
        enter_digit(SL_ADD, 5'd7);
        checks++; if (reg_a !== 16'h1234) begin errors++; $display("FAIL digit ignored: got %h want 1234", reg_a); end
        enter_digit(SL_B, 5'd5); enter_digit(SL_B, 5'd6);
        checks++; if (reg_b !== 16'h0056) begin errors++; $display("FAIL digit reg_b entry: got %h want 0056", reg_b); end
        enter_digit(SL_A, 5'd9);
        checks++; if (reg_a !== 16'h2349) begin errors++; $display("FAIL digit top discard: got %h want 2349", reg_a); end
    endtask

    task automatic test_add;
        load(16'h9999, 16'h9999);
        check_op("add", SL_ADD, 16'h9999, 16'h9999, 1'b0);
        checks++; if (reg_a !== 16'h3332 || carry !== 1'b1) begin
            errors++; $display("FAIL add literal: got %h/%b want 3332/1", reg_a, carry);
        end
    endtask

    task automatic test_sub;
        load(16'h0005, 16'h0007);
        check_op("sub_borrow", SL_SUB, 16'h0005, 16'h0007, 1'b0);
        checks++; if (reg_a !== 16'hFFFE || carry !== 1'b0) begin
            errors++; $display("FAIL sub_borrow literal: got %h/%b want fffe/0", reg_a, carry);
        end
        load(16'h0007, 16'h0005);
        check_op("sub_noborrow", SL_SUB, 16'h0007, 16'h0005, 1'b0);
        checks++; if (reg_a !== 16'h0002 || carry !== 1'b1) begin
            errors++; $display("FAIL sub_noborrow literal: got %h/%b want 0002/1", reg_a, carry);
        end
        load(16'h4321, 16'h4321);
        check_op("sub_equal", SL_SUB, 16'h4321, 16'h4321, 1'b0);
    endtask

    task automatic test_xor;
        int seen;
        load(16'h1234, 16'h1111);
        check_op("xor", SL_XOR, 16'h1234, 16'h1111, 1'b0);
        checks++; if (reg_a !== 16'h0325) begin errors++; $display("FAIL xor literal: got %h want 0325", reg_a); end
        // A start with a register select must not launch anything. A digit
        // write in the same cycle still lands, since sel picks reg_a.
        seen = 0;
        sel = SL_A; key = 5'd8; start = 1'b1; digit_wr = 1'b1;
        tick();
        start = 1'b0; digit_wr = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bad start busy: got %b want 0", busy); end
        for (int k = 0; k < NDIG + 3; k++) begin tick(); if (end_obl || busy) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL bad start activity: got %0d cycles want 0", seen); end
        checks++; if (reg_a !== 16'h3258) begin errors++; $display("FAIL bad start digit: got %h want 3258", reg_a); end
    endtask

    task automatic test_start_priority;
        load(16'h0012, 16'h0034);
        key = 5'd7; digit_wr = 1'b1;
        check_op("or_with_digit", SL_OR, 16'h0012, 16'h0034, 1'b0);
    endtask

    task automatic test_busy_lockout;
        load(16'h5678, 16'h1234);
        check_op("lockout", SL_ADD, 16'h5678, 16'h1234, 1'b1);
    endtask

    task automatic test_reset_mid_calc;
        int seen;
        load(16'h1234, 16'h1111);
        sel = SL_ADD; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset busy: got %b want 0", busy); end
        checks++; if (reg_a !== '0) begin errors++; $display("FAIL midreset reg_a: got %h want 0", reg_a); end
        checks++; if (reg_b !== '0 || end_obl !== 1'b0) begin
            errors++; $display("FAIL midreset reg_b/end_obl: got %h/%b want 0/0", reg_b, end_obl);
        end
        tick();
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < NDIG + 3; k++) begin tick(); if (end_obl || busy) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL midreset after: got %0d active cycles want 0", seen); end
    endtask

    task automatic test_random;
        logic [W-1:0] a, b;
        logic [2:0]   op;
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < NDIG; i++) begin
                a[i*4 +: 4] = 4'($urandom_range(9));
                b[i*4 +: 4] = 4'($urandom_range(9));
            end
            op = 3'($urandom_range(SL_ADD, SL_XOR));
            load(a, b);
            check_op("random", op, a, b, 1'($urandom_range(1)));
        end
    endtask

    initial begin
        test_reset();
        test_digit_entry();
        test_add();
        test_sub();
        test_xor();
        test_start_priority();
        test_busy_lockout();
        test_reset_mid_calc();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
